osnt_stamp_gen: RTL

Parametrised timestamp generator that replaces the plain free-running stamp counter in the OSNT datapath. It keeps a fixed-point accumulator advanced by a programmable per-cycle increment, so one clock can produce ns-scaled or fractional-rate time. It accepts atomic load/adjust commands over a valid/ready handshake and latches the current stamp on up to NUM_CAPTURE external trigger channels. It sits beside the MAC/timestamp taps and feeds STAMP_COUNTER to every stamping module.

---
 rtl/osnt_stamp_pkg.sv | 26 ++
 rtl/osnt_stamp_capture.sv | 48 ++++
 rtl/osnt_stamp_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/osnt_stamp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osnt_stamp_pkg
// Description : Shared opcodes, command FSM state type and default increment
//               for the OSNT fixed-point timestamp generator.
// Revision    : 1.0 - initial release
// ============================================================================
package osnt_stamp_pkg;

  // Command opcodes carried on CMD_OP
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Command FSM: IDLE accepts, APPLY commits the registered command
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } cmd_state_t;

  // +1 stamp per cycle with the default 32 fractional bits and 40-bit increment
  localparam logic [39:0] C_DEFAULT_INC = 40'h01_0000_0000;

endpackage : osnt_stamp_pkg
`default_nettype wire

// File: rtl/osnt_stamp_capture.sv
`default_nettype none
// ============================================================================
// Module      : osnt_stamp_capture
// Description : One capture channel. Detects a rising edge on its trigger,
//               latches the pre-edge stamp and pulses a one-cycle valid.
// Revision    : 1.0 - initial release
// ============================================================================
module osnt_stamp_capture
  import osnt_stamp_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = 64
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       CAP_TRIG,
  input  logic [TIMESTAMP_WIDTH-1:0] STAMP_IN,
  output logic                       CAP_VALID,
  output logic [TIMESTAMP_WIDTH-1:0] CAP_STAMP
);

  logic                       r_trig_d;
  logic                       r_cap_valid;
  logic [TIMESTAMP_WIDTH-1:0] r_cap_stamp;
  logic                       w_rise;

  // A held-high trigger only produces one capture
  assign w_rise = CAP_TRIG & ~r_trig_d;

  // Trigger history, capture latch and valid pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_trig_d    <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_stamp <= '0;
    end else begin
      r_trig_d    <= CAP_TRIG;
      r_cap_valid <= w_rise;
      if (w_rise) begin
        r_cap_stamp <= STAMP_IN;
      end
    end
  end

  assign CAP_VALID = r_cap_valid;
  assign CAP_STAMP = r_cap_stamp;

endmodule : osnt_stamp_capture
`default_nettype wire

// File: rtl/osnt_stamp_gen.sv
`default_nettype none
// ============================================================================
// Module      : osnt_stamp_gen
// Description : Fixed-point timestamp accumulator with programmable per-cycle
//               increment, atomic LOAD/ADD/SUB commands over valid/ready and
//               NUM_CAPTURE edge-triggered stamp capture channels.
// Revision    : 1.0 - initial release
// ============================================================================
module osnt_stamp_gen
  import osnt_stamp_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int FRAC_WIDTH      = 32,
  parameter int INC_WIDTH       = 40,
  parameter int NUM_CAPTURE     = 2
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic                                   ENABLE,
  input  logic [INC_WIDTH-1:0]                   CFG_INC,
  input  logic                                   CMD_VALID,
  output logic                                   CMD_READY,
  input  logic [1:0]                             CMD_OP,
  input  logic [TIMESTAMP_WIDTH-1:0]             CMD_VALUE,
  input  logic [NUM_CAPTURE-1:0]                 CAP_TRIG,
  output logic [NUM_CAPTURE-1:0]                 CAP_VALID,
  output logic [NUM_CAPTURE*TIMESTAMP_WIDTH-1:0] CAP_STAMP,
  output logic [TIMESTAMP_WIDTH-1:0]             STAMP_COUNTER,
  output logic                                   STAMP_WRAP
);

  localparam int ACC_WIDTH = TIMESTAMP_WIDTH + FRAC_WIDTH;
  // Two guard bits: ADD sums three terms, so the carry can exceed one bit
  localparam int SUM_WIDTH = ACC_WIDTH + 2;

  cmd_state_t                 r_state;
  cmd_state_t                 w_state_next;
  logic [1:0]                 r_op;
  logic [TIMESTAMP_WIDTH-1:0] r_value;
  logic [ACC_WIDTH-1:0]       r_acc;
  logic                       r_wrap;

  logic                       w_cmd_ready;
  logic                       w_apply;
  logic                       w_accept;
  logic [ACC_WIDTH-1:0]       w_inc;
  logic [ACC_WIDTH-1:0]       w_value_fx;
  logic [ACC_WIDTH:0]         w_sum_norm;
  logic [SUM_WIDTH-1:0]       w_sum_add;
  logic [ACC_WIDTH-1:0]       w_diff;
  logic [ACC_WIDTH-1:0]       w_acc_next;
  logic                       w_wrap_next;

  // Command FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Command FSM next state: APPLY always lasts exactly one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (CMD_VALID) w_state_next = ST_APPLY;
      ST_APPLY: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Command FSM outputs, decoded from the state register only
  always_comb begin
    w_cmd_ready = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE:  w_cmd_ready = 1'b1;
      ST_APPLY: w_apply     = 1'b1;
      default:  w_cmd_ready = 1'b0;
    endcase
  end

  assign w_accept  = CMD_VALID & w_cmd_ready;
  assign CMD_READY = w_cmd_ready;

  // Latch the opcode and operand of an accepted command
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_op    <= OP_NOP;
      r_value <= '0;
    end else if (w_accept) begin
      r_op    <= CMD_OP;
      r_value <= CMD_VALUE;
    end
  end

  // Candidate accumulator updates; all modulo 2^ACC_WIDTH
  assign w_inc      = ENABLE ? ACC_WIDTH'(CFG_INC) : '0;
  assign w_value_fx = {r_value, {FRAC_WIDTH{1'b0}}};
  assign w_sum_norm = {1'b0, r_acc} + {1'b0, w_inc};
  assign w_sum_add  = SUM_WIDTH'(r_acc) + SUM_WIDTH'(w_inc) + SUM_WIDTH'(w_value_fx);
  assign w_diff     = r_acc + w_inc - w_value_fx;

  // Select the accumulator update; only additions may flag a wrap
  always_comb begin
    w_acc_next  = w_sum_norm[ACC_WIDTH-1:0];
    w_wrap_next = w_sum_norm[ACC_WIDTH];
    if (w_apply) begin
      case (r_op)
        OP_LOAD: begin
          w_acc_next  = w_value_fx;
          w_wrap_next = 1'b0;
        end
        OP_ADD: begin
          w_acc_next  = w_sum_add[ACC_WIDTH-1:0];
          w_wrap_next = |w_sum_add[SUM_WIDTH-1:ACC_WIDTH];
        end
        OP_SUB: begin
          w_acc_next  = w_diff;
          w_wrap_next = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Accumulator and wrap pulse registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_acc  <= w_acc_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign STAMP_COUNTER = r_acc[ACC_WIDTH-1:FRAC_WIDTH];
  assign STAMP_WRAP    = r_wrap;

  // Capture channels sample the registered stamp, i.e. the pre-edge value
  for (genvar gi = 0; gi < NUM_CAPTURE; gi++) begin : g_capture
    osnt_stamp_capture #(
      .TIMESTAMP_WIDTH (TIMESTAMP_WIDTH)
    ) u_capture (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .CAP_TRIG  (CAP_TRIG[gi]),
      .STAMP_IN  (r_acc[ACC_WIDTH-1:FRAC_WIDTH]),
      .CAP_VALID (CAP_VALID[gi]),
      .CAP_STAMP (CAP_STAMP[gi*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH])
    );
  end : g_capture

endmodule : osnt_stamp_gen
`default_nettype wire
